// File: rtl/control_unit_mc_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU codes,
// FSM states and the decoded control word.
package control_unit_mc_pkg;

  localparam logic [3:0] OP_LI   = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;
  localparam logic [3:0] OP_IN   = 4'b1100;
  localparam logic [3:0] OP_OUT  = 4'b1101;
  localparam logic [3:0] OP_NOP  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [15:0] NOP_WORD = 16'hE000;

  typedef enum logic [2:0] {
    ALU_PASS, ALU_AND, ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH, ST_EXEC, ST_WAIT_IO, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    PCM_NONE, PCM_SEQ, PCM_JUMP, PCM_JZ, PCM_JNZ
  } pc_mode_e;

  typedef enum logic [1:0] {
    IOK_NONE, IOK_IN, IOK_OUT
  } io_kind_e;

  typedef struct packed {
    logic     is_alu;
    logic     we3;
    logic     s_inm;
    pc_mode_e pc_mode;
    io_kind_e io_kind;
    logic     halt;
  } ctrl_t;

endpackage

// File: rtl/control_unit_mc_if.sv
// Control-unit bus: program word, ALU flag and I/O handshake in; IR and
// datapath control out.
interface control_unit_mc_if #(
  parameter int unsigned IW = 16
);
  logic [IW-1:0] instr;
  logic          zero;
  logic          io_valid;
  logic          io_ready;
  logic [IW-1:0] ir;
  logic [2:0]    alu_op;
  logic          we3;
  logic          s_inm;
  logic          s_in;
  logic          pc_en;
  logic          pc_sel;
  logic          io_in_ack;
  logic          io_out_valid;
  logic          zflag;
  logic          halted;
  logic          io_err;

  modport master (
    input  instr, zero, io_valid, io_ready,
    output ir, alu_op, we3, s_inm, s_in, pc_en, pc_sel,
           io_in_ack, io_out_valid, zflag, halted, io_err
  );

  modport slave (
    output instr, zero, io_valid, io_ready,
    input  ir, alu_op, we3, s_inm, s_in, pc_en, pc_sel,
           io_in_ack, io_out_valid, zflag, halted, io_err
  );
endinterface

// File: rtl/control_unit_mc_decoder.sv
// Combinational opcode decoder: IR[15:12] to the static part of the control word.
module cu_decoder
  import control_unit_mc_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.pc_mode = PCM_NONE;
    ctrl_o.io_kind = IOK_NONE;
    if (!opcode_i[3]) begin
      ctrl_o.is_alu  = 1'b1;
      ctrl_o.we3     = 1'b1;
      ctrl_o.pc_mode = PCM_SEQ;
    end else begin
      unique case (opcode_i)
        OP_LI: begin
          ctrl_o.we3     = 1'b1;
          ctrl_o.s_inm   = 1'b1;
          ctrl_o.pc_mode = PCM_SEQ;
        end
        OP_J:    ctrl_o.pc_mode = PCM_JUMP;
        OP_JZ:   ctrl_o.pc_mode = PCM_JZ;
        OP_JNZ:  ctrl_o.pc_mode = PCM_JNZ;
        OP_IN:   ctrl_o.io_kind = IOK_IN;
        OP_OUT:  ctrl_o.io_kind = IOK_OUT;
        OP_NOP:  ctrl_o.pc_mode = PCM_SEQ;
        OP_HALT: ctrl_o.halt    = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control unit: FETCH/EXEC/WAIT_IO/HALT sequencer holding IR, zero
// flag, I/O wait timer and sticky error; strobes are decoded from the current state.
module control_unit_mc
  import control_unit_mc_pkg::*;
#(
  parameter int unsigned IW         = 16,
  parameter int unsigned IO_TIMEOUT = 0
) (
  input logic               clk,
  input logic               reset,
  control_unit_mc_if.master bus
);

  localparam int unsigned TW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  state_e        state_q;
  logic [IW-1:0] ir_q;
  logic          zflag_q;
  logic          halted_q;
  logic          io_err_q;
  logic [TW-1:0] timer_q;

  ctrl_t ctrl;
  logic  io_done;
  logic  wait_expired;

  cu_decoder u_dec (
    .opcode_i (ir_q[IW-1:IW-4]),
    .ctrl_o   (ctrl)
  );

  // Non-I/O instructions count as "done" so EXEC falls straight back to FETCH.
  always_comb begin
    unique case (ctrl.io_kind)
      IOK_IN:  io_done = bus.io_valid;
      IOK_OUT: io_done = bus.io_ready;
      default: io_done = 1'b1;
    endcase
    wait_expired = (IO_TIMEOUT != 0) && (state_q == ST_WAIT_IO) &&
                   ((32'(timer_q) + 32'd1) >= IO_TIMEOUT);
  end

  always_comb begin
    bus.we3          = 1'b0;
    bus.s_inm        = 1'b0;
    bus.s_in         = 1'b0;
    bus.pc_en        = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.io_in_ack    = 1'b0;
    bus.io_out_valid = 1'b0;
    if (state_q == ST_EXEC || state_q == ST_WAIT_IO) begin
      bus.we3          = ctrl.we3;
      bus.s_inm        = ctrl.s_inm;
      bus.s_in         = (ctrl.io_kind == IOK_IN);
      bus.io_out_valid = (ctrl.io_kind == IOK_OUT);
      unique case (ctrl.pc_mode)
        PCM_SEQ:  bus.pc_en = 1'b1;
        PCM_JUMP: begin bus.pc_en = 1'b1; bus.pc_sel = 1'b1;     end
        PCM_JZ:   begin bus.pc_en = 1'b1; bus.pc_sel = zflag_q;  end
        PCM_JNZ:  begin bus.pc_en = 1'b1; bus.pc_sel = ~zflag_q; end
        default:  ;
      endcase
      // A timed-out transfer still advances the PC but writes nothing.
      if (ctrl.io_kind != IOK_NONE) begin
        if (io_done) begin
          bus.pc_en     = 1'b1;
          bus.we3       = (ctrl.io_kind == IOK_IN);
          bus.io_in_ack = (ctrl.io_kind == IOK_IN);
        end else if (wait_expired) begin
          bus.pc_en = 1'b1;
        end
      end
    end
  end

  assign bus.alu_op = ctrl.is_alu ? ir_q[IW-2:IW-4] : ALU_PASS;
  assign bus.ir     = ir_q;
  assign bus.zflag  = zflag_q;
  assign bus.halted = halted_q;
  assign bus.io_err = io_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      ir_q     <= {NOP_WORD[15:12], {(IW-4){1'b0}}};
      zflag_q  <= 1'b0;
      halted_q <= 1'b0;
      io_err_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          ir_q    <= bus.instr;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ctrl.is_alu) zflag_q <= bus.zero;
          if (ctrl.halt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (!io_done) begin
            state_q <= ST_WAIT_IO;
            timer_q <= '0;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_WAIT_IO: begin
          if (io_done) begin
            state_q <= ST_FETCH;
          end else if (wait_expired) begin
            io_err_q <= 1'b1;
            state_q  <= ST_FETCH;
          end else if (IO_TIMEOUT != 0) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_HALT: ;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc: directed scenarios plus random
// instruction streams against an instruction-level reference model.
module tb_control_unit_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst4;
  logic [15:0] instr;
  logic        zero, io_valid, io_ready;

  control_unit_mc_if #(.IW(16)) bus0 ();
  control_unit_mc_if #(.IW(16)) bus4 ();

  assign bus0.instr = instr;    assign bus4.instr = instr;
  assign bus0.zero = zero;      assign bus4.zero = zero;
  assign bus0.io_valid = io_valid; assign bus4.io_valid = io_valid;
  assign bus0.io_ready = io_ready; assign bus4.io_ready = io_ready;

  control_unit_mc #(.IW(16), .IO_TIMEOUT(0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  control_unit_mc #(.IW(16), .IO_TIMEOUT(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  typedef struct packed {
    logic [15:0] ir;
    logic [2:0]  alu_op;
    logic we3, s_inm, s_in, pc_en, pc_sel, ack, ovalid, zflag, halted, io_err;
  } obs_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          use0;
  logic [15:0] m_ir;
  logic        m_z, m_halt, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t grab(input int which);
    obs_t o;
    if (which == 0)
      o = '{bus0.ir, bus0.alu_op, bus0.we3, bus0.s_inm, bus0.s_in, bus0.pc_en, bus0.pc_sel,
            bus0.io_in_ack, bus0.io_out_valid, bus0.zflag, bus0.halted, bus0.io_err};
    else
      o = '{bus4.ir, bus4.alu_op, bus4.we3, bus4.s_inm, bus4.s_in, bus4.pc_en, bus4.pc_sel,
            bus4.io_in_ack, bus4.io_out_valid, bus4.zflag, bus4.halted, bus4.io_err};
    return o;
  endfunction

  task automatic cmp_one(input string tag, input obs_t o, input obs_t e);
    chk({tag, ".ir"},     o.ir,     e.ir);
    chk({tag, ".alu_op"}, o.alu_op, e.alu_op);
    chk({tag, ".we3"},    o.we3,    e.we3);
    chk({tag, ".s_inm"},  o.s_inm,  e.s_inm);
    chk({tag, ".s_in"},   o.s_in,   e.s_in);
    chk({tag, ".pc_en"},  o.pc_en,  e.pc_en);
    chk({tag, ".pc_sel"}, o.pc_sel, e.pc_sel);
    chk({tag, ".ack"},    o.ack,    e.ack);
    chk({tag, ".ovalid"}, o.ovalid, e.ovalid);
    chk({tag, ".zflag"},  o.zflag,  e.zflag);
    chk({tag, ".halted"}, o.halted, e.halted);
    chk({tag, ".io_err"}, o.io_err, e.io_err);
  endtask

  task automatic check(input string tag, input obs_t e);
    #1;
    cmp_one({"t4.", tag}, grab(4), e);
    if (use0) cmp_one({"t0.", tag}, grab(0), e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // ALU instructions are opcodes 0..7; their low three opcode bits are the ALU op.
  function automatic logic [2:0] alu_of(input logic [15:0] w);
    int unsigned op = int'(w) / 4096;
    return (op < 8) ? 3'(op) : 3'd0;
  endfunction

  function automatic obs_t idle(input logic [15:0] w);
    obs_t e = '0;
    e.ir = w; e.alu_op = alu_of(w);
    e.zflag = m_z; e.halted = m_halt; e.io_err = m_err;
    return e;
  endfunction

  task automatic do_reset(input bit both);
    rst4 = 1'b1;
    if (both) rst0 = 1'b1;
    instr = 16'($urandom); zero = 1'($urandom);
    io_valid = 1'($urandom); io_ready = 1'($urandom);
    next();
    m_ir = 16'hE000; m_z = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    check("reset", idle(m_ir));
    rst4 = 1'b0;
    if (both) rst0 = 1'b0;
  endtask

  task automatic fetch_cycle(input logic [15:0] w);
    instr = w; zero = 1'($urandom); io_valid = 1'b0; io_ready = 1'b0;
    check("fetch", idle(m_ir));
    next();
    m_ir = w;
  endtask

  task automatic exec_cycles(input logic [15:0] w, input logic zv, input int nwait,
                             input int max_k);
    int unsigned op = int'(w) / 4096;
    obs_t e;
    bit   ready, tmo;
    for (int k = 0; k < max_k; k++) begin
      ready = (k >= nwait);
      tmo   = (k == 4) && !ready;
      instr = 16'($urandom); zero = zv;
      io_valid = (op == 12) ? ready : 1'($urandom);
      io_ready = (op == 13) ? ready : 1'($urandom);
      e = idle(w);
      if (op < 8) begin e.we3 = 1; e.pc_en = 1; end
      else case (op)
        8:  begin e.s_inm = 1; e.we3 = 1; e.pc_en = 1; end
        9:  begin e.pc_en = 1; e.pc_sel = 1; end
        10: begin e.pc_en = 1; e.pc_sel = m_z; end
        11: begin e.pc_en = 1; e.pc_sel = !m_z; end
        12: begin
          e.s_in = 1;
          if (ready) begin e.we3 = 1; e.ack = 1; e.pc_en = 1; end
          else if (tmo) e.pc_en = 1;
        end
        13: begin
          e.ovalid = 1;
          if (ready || tmo) e.pc_en = 1;
        end
        14: e.pc_en = 1;
        default: ;
      endcase
      check($sformatf("exec%0d_%h", k, w), e);
      next();
      if (op < 8) m_z = zv;
      if (op == 15) begin m_halt = 1; break; end
      if (tmo) m_err = 1;
      if ((op != 12 && op != 13) || ready || tmo) break;
    end
  endtask

  task automatic do_instr(input logic [15:0] w, input logic zv, input int nwait);
    fetch_cycle(w);
    exec_cycles(w, zv, nwait, 64);
  endtask

  initial begin
    obs_t e;
    int unsigned op;
    use0 = 1; rst0 = 0; rst4 = 0;
    instr = '0; zero = 0; io_valid = 0; io_ready = 0;
    next();
    do_reset(1);

    do_instr(16'h2123, 1'b0, 0);   // ADD
    do_instr(16'h3456, 1'b1, 0);   // SUB sets zflag
    do_instr(16'h8155, 1'b0, 0);   // LI holds zflag
    do_instr(16'hA005, 1'b0, 0);   // JZ taken
    do_instr(16'hB005, 1'b0, 0);   // JNZ not taken
    do_instr(16'h1000, 1'b0, 0);
    do_instr(16'hA005, 1'b1, 0);   // JZ not taken
    do_instr(16'hB005, 1'b1, 0);   // JNZ taken
    do_instr(16'hC300, 1'b0, 3);   // IN after 3 stalled cycles
    do_instr(16'hD200, 1'b0, 0);   // OUT with ready already high
    do_instr(16'hD200, 1'b0, 2);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 14);
      do_instr({4'(op), 12'($urandom)}, 1'($urandom), $urandom_range(0, 3));
    end

    // Timeout only on the IO_TIMEOUT=4 instance; the other is parked in reset.
    use0 = 0; rst0 = 1;
    do_instr(16'hD200, 1'b0, 100);
    do_instr(16'hE000, 1'b0, 0);
    do_instr(16'hC100, 1'b0, 100);
    fetch_cycle(16'hD200);
    exec_cycles(16'hD200, 1'b0, 100, 3);
    rst4 = 1'b1; io_ready = 1'b0;
    next();
    m_ir = 16'hE000; m_z = 0; m_halt = 0; m_err = 0;
    check("midwait_reset", idle(16'hE000));
    rst4 = 1'b0;
    use0 = 1;
    do_reset(1);

    do_instr(16'h4777, 1'b1, 0);
    do_instr(16'hF000, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      instr = 16'($urandom); zero = 1'($urandom);
      io_valid = 1'($urandom); io_ready = 1'($urandom);
      e = idle(16'hF000);
      check($sformatf("halt%0d", i), e);
      next();
    end
    do_reset(1);
    do_instr(16'h2123, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
